expander_graph_dma_rd: RTL

Read-side DMA engine that feeds the expander-graph encoding stage. On a start pulse it fetches a contiguous region of `num_beats_i` memory beats in bursts of up to `MAX_BURST` beats, buffers the returned data in an internal FIFO, and streams it downstream over a valid/ready interface. Credit-based request issue guarantees the FIFO never overflows, so the memory response channel needs no backpressure. The control FSM uses the codebase's DMA state set: IDLE, INIT, EXEC, DONE.

---
 rtl/expander_graph_dma_rd.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/expander_graph_dma_rd.sv
// expander_graph_dma_rd
// Read-side DMA engine feeding the expander-graph encoding stage. A start
// pulse fetches num_beats_i contiguous beats in bursts of up to MAX_BURST
// beats. Returned beats are buffered in an internal FIFO and streamed out
// over a valid/ready port. Requests only issue when the FIFO has room
// reserved for every beat of the burst, so the response channel needs no
// backpressure.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i                    start pulse (sampled in IDLE only)
//   base_addr_i, num_beats_i   transfer base byte address and beat count
//   busy_o, done_o             state != IDLE, one-cycle completion pulse
//   rd_req_*                   burst read request channel (valid/ready)
//   rd_rsp_*                   in-order response beats, no ready
//   m_*                        downstream beat stream (valid/ready, last)
//
// Handshake rule for both valid/ready channels: a transfer happens on a
// rising clk edge where valid and ready are both high; once valid is raised
// it is not withdrawn and its payload stays stable until that transfer.
module expander_graph_dma_rd #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 256,
    parameter int LEN_W      = 5,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  num_beats_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_req_valid_o,
    input  logic              rd_req_ready_i,
    output logic [ADDR_W-1:0] rd_req_addr_o,
    output logic [LEN_W-1:0]  rd_req_len_o,
    input  logic              rd_rsp_valid_i,
    input  logic [DATA_W-1:0] rd_rsp_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CRD_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_req_addr;
    logic [CNT_W-1:0]  r_req_left;
    logic [CNT_W-1:0]  r_pop_left;
    logic [CRD_W-1:0]  r_credits;
    logic [CRD_W-1:0]  r_fifo_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    logic [LEN_W-1:0]  w_len;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_m_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_last_pop;

    always_comb begin
        if (r_req_left >= CNT_W'(MAX_BURST)) begin
            w_len = LEN_W'(MAX_BURST);
        end else begin
            w_len = r_req_left[LEN_W-1:0];
        end
    end

    // A burst is only offered when the FIFO space for all of its beats is
    // already reserved; this is what makes the response channel safe.
    assign w_req_valid = (r_state == S_EXEC) && (r_req_left != '0) &&
                         (r_credits >= CRD_W'(w_len));
    assign w_req_fire  = w_req_valid && rd_req_ready_i;
    assign w_m_valid   = (r_state == S_EXEC) && (r_fifo_cnt != '0);
    assign w_pop       = w_m_valid && m_ready_i;
    // Beats are only accepted while a transfer is executing (dropped in IDLE).
    assign w_push      = rd_rsp_valid_i && (r_state == S_EXEC);
    assign w_last_pop  = w_pop && (r_pop_left == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (num_beats_i != '0) ? S_INIT : S_DONE;
                end
            end
            S_INIT:  w_next = S_EXEC;
            S_EXEC: begin
                if (w_last_pop) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_count    <= '0;
            r_req_addr <= '0;
            r_req_left <= '0;
            r_pop_left <= '0;
            r_credits  <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_base  <= base_addr_i & ~ADDR_W'(BYTES - 1);
                        r_count <= num_beats_i;
                    end
                end
                S_INIT: begin
                    r_req_addr <= r_base;
                    r_req_left <= r_count;
                    r_pop_left <= r_count;
                    r_credits  <= CRD_W'(FIFO_DEPTH);
                    r_fifo_cnt <= '0;
                    r_wr_ptr   <= '0;
                    r_rd_ptr   <= '0;
                end
                S_EXEC: begin
                    if (w_req_fire) begin
                        r_req_addr <= r_req_addr + (ADDR_W'(w_len) << OFF_W);
                        r_req_left <= r_req_left - CNT_W'(w_len);
                    end
                    // Issue and pop may coincide: net credit change is +pop-len.
                    r_credits <= r_credits + CRD_W'(w_pop) -
                                 (w_req_fire ? CRD_W'(w_len) : '0);
                    if (w_pop) begin
                        r_pop_left <= r_pop_left - CNT_W'(1);
                        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                    end
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    end
                    r_fifo_cnt <= r_fifo_cnt + CRD_W'(w_push) - CRD_W'(w_pop);
                end
                default: begin
                end
            endcase
        end
    end

    // Storage needs no reset: the read port is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rd_rsp_data_i;
        end
    end

    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_DONE);
    assign rd_req_valid_o = w_req_valid;
    assign rd_req_addr_o  = r_req_addr;
    assign rd_req_len_o   = w_len;
    assign m_valid_o      = w_m_valid;
    assign m_data_o       = w_m_valid ? r_mem[r_rd_ptr] : '0;
    assign m_last_o       = w_m_valid && (r_pop_left == CNT_W'(1));

endmodule
